// File: rtl/scffi_mode_cfg_ctrl.sv
// Configuration-chain controller: buffers NUM_TILES mode words and serializes them into the CCFF chain.
// Optional read-back verify pass enabled by defining SCFFI_CFG_VERIFY_EN.
module scffi_mode_cfg_ctrl #(
    parameter int NUM_TILES = 4,
    parameter int MODE_W    = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [MODE_W-1:0] cfg_data_i,
    output logic              ccff_head_o,
    output logic              ccff_shift_o,
    input  logic              ccff_tail_i,
    output logic              tile_clr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int TOTAL_BITS = NUM_TILES * MODE_W;
    localparam int BIT_CNT_W  = $clog2(TOTAL_BITS + 1);
    localparam int WORD_CNT_W = $clog2(NUM_TILES + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q;
    logic [BIT_CNT_W-1:0]    bit_cnt_q;
    logic [TOTAL_BITS-1:0]   stream_q;
    logic [TOTAL_BITS-1:0]   stream_load;
    logic [TOTAL_BITS-1:0]   stream_rot;
    logic                    head_q;
    logic                    head_d;
    logic                    accept;
    logic                    last_word;
    logic                    last_bit;
    logic                    start_ok;
    logic                    shifting;
    logic                    shifting_next;

    assign accept    = cfg_valid_i && (state_q == ST_LOAD);
    assign last_word = accept && (word_cnt_q == WORD_CNT_W'(NUM_TILES - 1));
    assign last_bit  = (bit_cnt_q == BIT_CNT_W'(TOTAL_BITS - 1));
    assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign shifting  = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
    assign shifting_next = (state_d == ST_SHIFT) || (state_d == ST_VERIFY);

    // Words enter at the top and slide down, so after the last word the
    // register equals {word[N-1], ..., word[0]} and the stream is read MSB first.
    assign stream_load = (stream_q >> MODE_W) | (TOTAL_BITS'(cfg_data_i) << (TOTAL_BITS - MODE_W));
    // Rotating keeps the full image intact after one pass, ready for a resend.
    assign stream_rot  = (stream_q << 1) | (stream_q >> (TOTAL_BITS - 1));

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (last_word) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SCFFI_CFG_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_VERIFY: begin
                if (last_bit) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first bit of the stream is the MSB of the final word, which is not
    // yet in the buffer on the accepting edge, so it comes straight from the port.
    always_comb begin
        head_d = 1'b0;
        if (last_word) begin
            head_d = cfg_data_i[MODE_W-1];
        end else if (shifting_next) begin
            head_d = stream_rot[TOTAL_BITS-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            head_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                word_cnt_q <= '0;
            end else if (accept) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end

            if (shifting && !last_bit) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end else begin
                bit_cnt_q <= '0;
            end

            head_q <= head_d;
        end
    end

    // NOTE: the word buffer carries no reset; its contents are meaningless
    // until a full LOAD has refilled it.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            stream_q <= stream_load;
        end else if (shifting) begin
            stream_q <= stream_rot;
        end
    end

`ifdef SCFFI_CFG_VERIFY_EN
    logic err_q;

    // During the second pass the tail emits pass-1 bit i exactly when the head
    // re-sends bit i, so a plain compare against the head register suffices.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_VERIFY) && (ccff_tail_i != head_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail_i;
    assign err_o       = 1'b0;
`endif

    assign cfg_ready_o  = (state_q == ST_LOAD);
    assign ccff_shift_o = shifting;
    assign ccff_head_o  = head_q;
    assign tile_clr_o   = (state_q == ST_LOAD) || shifting;
    assign busy_o       = (state_q == ST_LOAD) || shifting;
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_scffi_mode_cfg_ctrl.sv
// Scoreboard bench for scffi_mode_cfg_ctrl with a behavioural model of the CCFF chain.
`timescale 1ns/1ps
module tb_scffi_mode_cfg_ctrl;

    localparam int NT = 2;
    localparam int MW = 7;
    localparam int T  = NT * MW;
`ifdef SCFFI_CFG_VERIFY_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [MW-1:0] cfg_data_i;
    logic          ccff_head_o;
    logic          ccff_shift_o;
    logic          ccff_tail_i;
    logic          tile_clr_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    scffi_mode_cfg_ctrl #(.NUM_TILES(NT), .MODE_W(MW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_data_i   (cfg_data_i),
        .ccff_head_o  (ccff_head_o),
        .ccff_shift_o (ccff_shift_o),
        .ccff_tail_i  (ccff_tail_i),
        .tile_clr_o   (tile_clr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Chain model: position 0 next to the head, tail at position T-1.
    logic [T-1:0] chain = '0;
    logic [T-1:0] stuck_mask = '0;
    always @(posedge clk_i) begin
        if (ccff_shift_o) chain <= {chain[T-2:0], ccff_head_o} & ~stuck_mask;
    end
    assign ccff_tail_i = chain[T-1];

    int n_tests = 0;
    int n_fail  = 0;
    int shift_total = 0;
    bit exp_q[$];
    logic ready_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic observe();
        if (!rst_i && ccff_shift_o) begin
            shift_total++;
            if (exp_q.size() == 0) check("extra_shift", 32'd1, 32'd0);
            else check("head_bit", 32'(ccff_head_o), 32'(exp_q.pop_front()));
        end
    endtask

    // One clock: sample at the falling edge, then step just past the rising edge.
    task automatic cycle();
        @(negedge clk_i);
        observe();
        ready_seen = cfg_ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_stream(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] w [NT];
        w[0] = a;
        w[1] = b;
        for (int p = 0; p < PASSES; p++)
            for (int k = NT - 1; k >= 0; k--)
                for (int j = MW - 1; j >= 0; j--)
                    exp_q.push_back(w[k][j]);
    endtask

    task automatic load_word(input logic [MW-1:0] w, input int gap, input bit last);
        bit ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            cfg_valid_i = 1'b0;
            cycle();
        end
        cfg_valid_i = 1'b1;
        cfg_data_i  = w;
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (ready_seen) begin
                ok = 1'b1;
                break;
            end
        end
        check("load_accept", 32'(ok), 32'd1);
        cfg_valid_i = 1'b0;
        if (last) check("ready_drop", 32'(cfg_ready_o), 32'd0);
        else      check("ready_hold", 32'(cfg_ready_o), 32'd1);
    endtask

    task automatic begin_session(input logic [MW-1:0] a, input logic [MW-1:0] b, input int gap);
        push_stream(a, b);
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        check("load_flags", {28'd0, busy_o, tile_clr_o, cfg_ready_o, done_o}, 32'hE);
        check("err_clr_on_start", 32'(err_o), 32'd0);
        load_word(a, gap, 1'b0);
        load_word(b, gap, 1'b1);
    endtask

    task automatic end_session(input int base, input logic [MW-1:0] a, input logic [MW-1:0] b,
                               input bit chk_chain, input bit exp_err);
        for (int i = 0; i < 200; i++) begin
            if (done_o) break;
            cycle();
        end
        check("done", 32'(done_o), 32'd1);
        check("shift_count", 32'(shift_total - base), 32'(T * PASSES));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_outs", {27'd0, ccff_shift_o, ccff_head_o, tile_clr_o, busy_o, cfg_ready_o}, 32'd0);
        check("err", 32'(err_o), 32'(exp_err));
        if (chk_chain) begin
            check("tile0", 32'(chain[MW-1:0]), 32'(a));
            check("tile1", 32'(chain[T-1:MW]), 32'(b));
        end
    endtask

    int base;

    initial begin
        rst_i       = 1'b0;
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_data_i  = '0;

        // Reset asserted between clock edges, then idle with no start.
        #12 rst_i = 1'b1;
        #1;
        check("rst_outs", {25'd0, cfg_ready_o, ccff_head_o, ccff_shift_o, tile_clr_o,
                           busy_o, done_o, err_o}, 32'd0);
        cycle();
        cycle();
        rst_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("idle_busy", 32'(busy_o), 32'd0);
        end

        // Basic back-to-back load.
        base = shift_total;
        begin_session(7'h55, 7'h0F, 0);
        end_session(base, 7'h55, 7'h0F, 1'b1, 1'b0);
        check("tile_clr_done", 32'(tile_clr_o), 32'd0);

        // Gapped valid: one word every third cycle.
        base = shift_total;
        begin_session(7'h55, 7'h0F, 2);
        end_session(base, 7'h55, 7'h0F, 1'b1, 1'b0);

        // start_i and cfg_valid_i during SHIFT must be ignored.
        base = shift_total;
        begin_session(7'h2A, 7'h61, 0);
        start_i     = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_data_i  = 7'h33;
        cycle();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("ready_in_shift", 32'(cfg_ready_o), 32'd0);
            cycle();
        end
        cfg_valid_i = 1'b0;
        check("busy_in_shift", 32'(busy_o), 32'd1);
        end_session(base, 7'h2A, 7'h61, 1'b1, 1'b0);

        // Reset during the fifth shift cycle, then reprogram.
        begin_session(7'h11, 7'h6C, 0);
        for (int i = 0; i < 4; i++) cycle();
        rst_i = 1'b1;
        #1;
        check("midrst_outs", {25'd0, cfg_ready_o, ccff_head_o, ccff_shift_o, tile_clr_o,
                              busy_o, done_o, err_o}, 32'd0);
        exp_q.delete();
        cycle();
        cycle();
        rst_i = 1'b0;
        cycle();
        base = shift_total;
        begin_session(7'h7F, 7'h00, 0);
        end_session(base, 7'h7F, 7'h00, 1'b1, 1'b0);

`ifdef SCFFI_CFG_VERIFY_EN
        // Stuck-at-0 chain cell: verify pass must flag it and hold err_o.
        stuck_mask = 14'h0008;
        base = shift_total;
        begin_session(7'h7F, 7'h7F, 0);
        end_session(base, 7'h7F, 7'h7F, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle();
        check("err_sticky", 32'(err_o), 32'd1);
        check("done_sticky", 32'(done_o), 32'd1);
        stuck_mask = '0;
        base = shift_total;
        begin_session(7'h7F, 7'h7F, 0);
        end_session(base, 7'h7F, 7'h7F, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
